// File: rtl/addr_reg_xy_decode_seq.sv
// Serially loaded memory address register with X-low/Y/X-high one-hot select decode.
// Optional even-parity check on the serial load, enabled by defining ADDR_PARITY_EN.
module addr_reg_xy_decode_seq #(
    parameter int XL_BITS = 3,
    parameter int Y_BITS  = 3,
    parameter int XH_BITS = 3
) (
    input  logic                                  CLK,
    input  logic                                  RESETN,
    input  logic                                  LOAD,
    input  logic                                  TR_BIT,
    input  logic                                  TR_VALID,
    input  logic                                  INC,
    input  logic                                  SEL_EN,
    output logic [XL_BITS+Y_BITS+XH_BITS-1:0]     ADDR,
    output logic                                  BUSY,
    output logic                                  DONE,
    output logic [(2**XL_BITS)-1:0]               AXL_N,
    output logic [(2**Y_BITS)-1:0]                AY_N,
    output logic [(2**XH_BITS)-1:0]               AXH_N,
    output logic                                  PAR_ERR
);

    localparam int A_BITS = XL_BITS + Y_BITS + XH_BITS;
`ifdef ADDR_PARITY_EN
    localparam int N_BITS = A_BITS + 1;
`else
    localparam int N_BITS = A_BITS;
`endif
    localparam int CNT_W = $clog2(N_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);
    localparam int NXL = 2 ** XL_BITS;
    localparam int NY  = 2 ** Y_BITS;
    localparam int NXH = 2 ** XH_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [A_BITS-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [NXL-1:0]      axl_q, axl_d;
    logic [NY-1:0]       ay_q, ay_d;
    logic [NXH-1:0]      axh_q, axh_d;
    logic                sel_on;

    logic [XL_BITS-1:0]  xl_f;
    logic [Y_BITS-1:0]   y_f;
    logic [XH_BITS-1:0]  xh_f;

`ifdef ADDR_PARITY_EN
    logic                par_err_q, par_err_d;
`endif

    assign xl_f = addr_q[XL_BITS-1:0];
    assign y_f  = addr_q[XL_BITS+Y_BITS-1:XL_BITS];
    assign xh_f = addr_q[A_BITS-1:XL_BITS+Y_BITS];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef ADDR_PARITY_EN
        par_err_d = par_err_q;
`endif
        // LOAD restarts the load from any state, including mid-shift
        if (LOAD) begin
            state_d = S_SHIFT;
            addr_d  = '0;
            cnt_d   = '0;
`ifdef ADDR_PARITY_EN
            par_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (TR_VALID) begin
                        cnt_d = cnt_q + 1'b1;
`ifdef ADDR_PARITY_EN
                        if (cnt_q < CNT_W'(A_BITS)) begin
                            addr_d[cnt_q] = TR_BIT;
                        end else begin
                            par_err_d = TR_BIT ^ (^addr_q);
                        end
`else
                        addr_d[cnt_q] = TR_BIT;
`endif
                        if (cnt_q == LAST_CNT) begin
                            state_d = S_READY;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_READY: begin
                    if (INC) begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Selects only assert when READY holds across the edge, so SHIFT is always clear
    always_comb begin
        sel_on = (state_q == S_READY) && (state_d == S_READY) && SEL_EN;
`ifdef ADDR_PARITY_EN
        sel_on = sel_on && !par_err_q;
`endif
        axl_d = '1;
        ay_d  = '1;
        axh_d = '1;
        if (sel_on) begin
            axl_d[xl_f] = 1'b0;
            ay_d[y_f]   = 1'b0;
            axh_d[xh_f] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            axl_q   <= '1;
            ay_q    <= '1;
            axh_q   <= '1;
`ifdef ADDR_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            axl_q   <= axl_d;
            ay_q    <= ay_d;
            axh_q   <= axh_d;
`ifdef ADDR_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign ADDR  = addr_q;
    assign BUSY  = (state_q == S_SHIFT);
    assign DONE  = done_q;
    assign AXL_N = axl_q;
    assign AY_N  = ay_q;
    assign AXH_N = axh_q;
`ifdef ADDR_PARITY_EN
    assign PAR_ERR = par_err_q;
`else
    assign PAR_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_addr_reg_xy_decode_seq.sv
// Bench for addr_reg_xy_decode_seq: directed loads, scoreboard checked on DONE.
// Builds with or without ADDR_PARITY_EN.
module tb_addr_reg_xy_decode_seq;

    logic       CLK = 1'b0;
    logic       RESETN, LOAD, TR_BIT, TR_VALID, INC, SEL_EN;
    logic [8:0] ADDR;
    logic       BUSY, DONE, PAR_ERR;
    logic [7:0] AXL_N, AY_N, AXH_N;

`ifdef ADDR_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [8:0] addr;
        logic [7:0] axl;
        logic [7:0] ay;
        logic [7:0] axh;
        logic       par;
        int         dcyc;
    } exp_t;

    exp_t q[$];

    addr_reg_xy_decode_seq dut (
        .CLK(CLK), .RESETN(RESETN), .LOAD(LOAD), .TR_BIT(TR_BIT),
        .TR_VALID(TR_VALID), .INC(INC), .SEL_EN(SEL_EN), .ADDR(ADDR),
        .BUSY(BUSY), .DONE(DONE), .AXL_N(AXL_N), .AY_N(AY_N),
        .AXH_N(AXH_N), .PAR_ERR(PAR_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_addr(input logic [8:0] a, input logic [9:0] stall,
                             input bit flip, input bit inc_on,
                             input logic [7:0] exl, input logic [7:0] ey,
                             input logic [7:0] exh, input logic ep);
        int   c0;
        int   ns;
        exp_t e;
        ns = 0;
        for (int i = 0; i < NB; i++) if (stall[i]) ns++;
        LOAD = 1'b1;
        INC  = inc_on;
        tick();
        LOAD = 1'b0;
        c0 = cyc;
        chk("load_busy", {31'd0, BUSY}, 32'd1);
        chk("load_clr", {23'd0, ADDR}, 32'd0);
        chk("load_sel", {8'd0, AXL_N, AY_N, AXH_N}, 32'h00FFFFFF);
        e.addr = a;
        e.axl  = exl;
        e.ay   = ey;
        e.axh  = exh;
        e.par  = ep;
        e.dcyc = c0 + NB + ns;
        q.push_back(e);
        for (int i = 0; i < NB; i++) begin
            if (stall[i]) begin
                TR_VALID = 1'b0;
                TR_BIT   = 1'b1;
                tick();
            end
            TR_VALID = 1'b1;
            TR_BIT   = (i < 9) ? a[i] : ((^a) ^ flip);
            tick();
        end
        TR_VALID = 1'b0;
        TR_BIT   = 1'b0;
        INC      = 1'b0;
    endtask

    // Monitor: on each DONE pulse pop an expectation, then check decode next cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", cyc, e.dcyc);
                    chk("done_addr", {23'd0, ADDR}, {23'd0, e.addr});
                    chk("done_par", {31'd0, PAR_ERR}, {31'd0, e.par});
                    @(negedge CLK);
                    chk("done_pulse", {31'd0, DONE}, 32'd0);
                    chk("sel_axl", {24'd0, AXL_N}, {24'd0, e.axl});
                    chk("sel_ay", {24'd0, AY_N}, {24'd0, e.ay});
                    chk("sel_axh", {24'd0, AXH_N}, {24'd0, e.axh});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETN = 1'b0; LOAD = 1'b0; TR_BIT = 1'b0;
        TR_VALID = 1'b0; INC = 1'b0; SEL_EN = 1'b1;
        tick(); tick();
        RESETN = 1'b1;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_addr", {23'd0, ADDR}, 32'd0);
        chk("rst_par", {31'd0, PAR_ERR}, 32'd0);
        chk("rst_sel", {8'd0, AXL_N, AY_N, AXH_N}, 32'h00FFFFFF);

        // reset mid-shift after bits 1,0,1,1
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        TR_VALID = 1'b1;
        TR_BIT = 1'b1; tick();
        TR_BIT = 1'b0; tick();
        TR_BIT = 1'b1; tick();
        TR_BIT = 1'b1; tick();
        TR_VALID = 1'b0;
        chk("part_addr", {23'd0, ADDR}, 32'h00D);
        chk("part_busy", {31'd0, BUSY}, 32'd1);
        RESETN = 1'b0; tick(); RESETN = 1'b1;
        chk("mid_rst_addr", {23'd0, ADDR}, 32'd0);
        chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
        chk("mid_rst_done", {31'd0, DONE}, 32'd0);
        chk("mid_rst_sel", {8'd0, AXL_N, AY_N, AXH_N}, 32'h00FFFFFF);

        // plain load of 0x0B5
        load_addr(9'h0B5, 10'd0, 1'b0, 1'b0, 8'hDF, 8'hBF, 8'hFB, 1'b0);
        tick(); tick(); tick();

        // stalls before bits 3 and 7, INC held during shift (ignored)
        load_addr(9'h0B5, 10'b0010001000, 1'b0, 1'b1, 8'hDF, 8'hBF, 8'hFB, 1'b0);
        tick(); tick(); tick();

        // load all-ones, then increment wrap
        load_addr(9'h1FF, 10'd0, 1'b0, 1'b0, 8'h7F, 8'h7F, 8'h7F, 1'b0);
        tick(); tick(); tick();
        INC = 1'b1; tick();
        chk("wrap_addr", {23'd0, ADDR}, 32'd0);
        chk("wrap_sel_old", {8'd0, AXL_N, AY_N, AXH_N}, 32'h007F7F7F);
        INC = 1'b0; tick();
        chk("wrap_sel_new", {8'd0, AXL_N, AY_N, AXH_N}, 32'h00FEFEFE);
        chk("wrap_hold", {23'd0, ADDR}, 32'd0);
        INC = 1'b1; tick();
        chk("inc_one", {23'd0, ADDR}, 32'd1);
        LOAD = 1'b1; tick();
        LOAD = 1'b0; INC = 1'b0;
        chk("ldinc_addr", {23'd0, ADDR}, 32'd0);
        chk("ldinc_busy", {31'd0, BUSY}, 32'd1);
        chk("ldinc_sel", {8'd0, AXL_N, AY_N, AXH_N}, 32'h00FFFFFF);

        // 5 bits then abort with a full load of 0x003, decode disabled
        TR_VALID = 1'b1; TR_BIT = 1'b1;
        repeat (5) tick();
        TR_VALID = 1'b0;
        chk("pre_abort_addr", {23'd0, ADDR}, 32'h01F);
        SEL_EN = 1'b0;
        load_addr(9'h003, 10'd0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        tick(); tick(); tick();
        SEL_EN = 1'b1;

`ifdef ADDR_PARITY_EN
        load_addr(9'h0B5, 10'd0, 1'b0, 1'b0, 8'hDF, 8'hBF, 8'hFB, 1'b0);
        tick(); tick(); tick();
        load_addr(9'h0B5, 10'd0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        tick(); tick(); tick();
        INC = 1'b1; tick(); INC = 1'b0; tick();
        chk("perr_inc_addr", {23'd0, ADDR}, 32'h0B6);
        chk("perr_inc_keep", {31'd0, PAR_ERR}, 32'd1);
        chk("perr_inc_sel", {8'd0, AXL_N, AY_N, AXH_N}, 32'h00FFFFFF);
        LOAD = 1'b1; tick(); LOAD = 1'b0;
        chk("perr_load_clr", {31'd0, PAR_ERR}, 32'd0);
`endif

        tick(); tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
